// File: rtl/gray_decode_arbiter_if.sv
// rtl/gray_decode_arbiter_if.sv - requester/consumer bus bundle for the shared Gray decoder
interface gray_decode_arbiter_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_gray;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_binary;
    logic [ID_W-1:0]          out_id;
    logic                     out_ready;
    logic [CNT_W-1:0]         conv_count;
    logic                     busy;

    modport master (
        output req_valid, req_gray, out_ready,
        input  req_ready, out_valid, out_binary, out_id, conv_count, busy
    );

    modport slave (
        input  req_valid, req_gray, out_ready,
        output req_ready, out_valid, out_binary, out_id, conv_count, busy
    );
endinterface

// File: rtl/gray_decode_arbiter.sv
// rtl/gray_decode_arbiter.sv - round-robin shared Gray-to-binary converter with one registered output
module gray_decode_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    gray_decode_arbiter_if.slave   bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  idx;
    logic             grant_found;
    logic             can_accept;
    logic [WIDTH-1:0] gray_sel;
    logic [WIDTH-1:0] bin_sel;
    logic             acc;
    logic [WIDTH-1:0] out_binary_r;
    logic [ID_W-1:0]  out_id_r;
    logic [CNT_W-1:0] count_r;

    // A full register may be drained and refilled in the same cycle.
    assign can_accept = (state == EMPTY) || bus.out_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        gray_sel    = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!grant_found && can_accept && !rst && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
                gray_sel    = bus.req_gray[int'(idx)*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Binary bit k is the XOR of all Gray bits at or above k.
    always_comb begin
        bin_sel = '0;
        acc     = gray_sel[WIDTH-1];
        bin_sel[WIDTH-1] = acc;
        for (int k = WIDTH - 2; k >= 0; k--) begin
            acc        = acc ^ gray_sel[k];
            bin_sel[k] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            out_binary_r <= '0;
            out_id_r     <= '0;
            ptr          <= '0;
            count_r      <= '0;
        end else if (grant_found) begin
            state        <= FULL;
            out_binary_r <= bin_sel;
            out_id_r     <= grant_idx;
            ptr          <= grant_idx + ID_W'(1);
            count_r      <= count_r + CNT_W'(1);
        end else if (state == FULL && bus.out_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.out_valid  = (state == FULL);
    assign bus.busy       = (state == FULL);
    assign bus.out_binary = out_binary_r;
    assign bus.out_id     = out_id_r;
    assign bus.conv_count = count_r;
endmodule

// File: tb/tb_gray_decode_arbiter.sv
// tb/tb_gray_decode_arbiter.sv - randomized and directed bench with a behavioural reference model
module tb_gray_decode_arbiter;
    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic       m_valid;
    logic [3:0] m_bin;
    logic [1:0] m_id;
    int         m_ptr;
    int         m_cnt;
    logic [3:0] held_bin;
    logic [1:0] held_id;
    logic [15:0] held_cnt;

    gray_decode_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    gray_decode_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b = 4'd0;
        for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int exp_grant();
        if (rst || (m_valid && !bus.out_ready)) return -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (bus.req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_bin   = 4'd0;
        m_id    = 2'd0;
        m_ptr   = 0;
        m_cnt   = 0;
    endfunction

    // Check at the falling edge, then advance the model to what the rising edge will produce.
    task automatic cyc();
        int g;
        @(negedge clk);
        g = exp_grant();
        chk("req_ready", {28'd0, bus.req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("busy", {31'd0, bus.busy}, {31'd0, m_valid});
        chk("out_binary", {28'd0, bus.out_binary}, {28'd0, m_bin});
        chk("out_id", {30'd0, bus.out_id}, {30'd0, m_id});
        chk("conv_count", {16'd0, bus.conv_count}, m_cnt);
        if (rst) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_bin   = gray2bin(bus.req_gray[g*WIDTH +: WIDTH]);
            m_id    = 2'(g);
            m_ptr   = (g + 1) % NUM_REQ;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_bins [4];
        int         exp_ids  [3];
        checks = 0;
        errors = 0;
        exp_bins[0] = 4'b0001;
        exp_bins[1] = 4'b0010;
        exp_bins[2] = 4'b1000;
        exp_bins[3] = 4'b1011;
        exp_ids[0] = 3;
        exp_ids[1] = 1;
        exp_ids[2] = 3;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_gray  = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cyc();
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_conv_count", {16'd0, bus.conv_count}, 32'd0);

        // Single conversion of Gray 0110.
        rst           = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_gray  = 16'h0006;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_req_ready", {28'd0, bus.req_ready}, 32'd1);
        cyc();
        bus.req_valid = '0;
        chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_out_binary", {28'd0, bus.out_binary}, 32'b0100);
        chk("t1_out_id", {30'd0, bus.out_id}, 32'd0);
        chk("t1_conv_count", {16'd0, bus.conv_count}, 32'd1);

        // Four continuous requesters, pointer starting at 0.
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_gray  = {4'b1110, 4'b1100, 4'b0011, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t2_out_id", {30'd0, bus.out_id}, i % 4);
            chk("t2_out_binary", {28'd0, bus.out_binary}, {28'd0, exp_bins[i % 4]});
        end

        // Backpressure for three cycles, then resume with no bubble.
        held_bin      = bus.out_binary;
        held_id       = bus.out_id;
        held_cnt      = bus.conv_count;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_req_ready", {28'd0, bus.req_ready}, 32'd0);
            cyc();
            chk("t3_held_binary", {28'd0, bus.out_binary}, {28'd0, held_bin});
            chk("t3_held_id", {30'd0, bus.out_id}, {30'd0, held_id});
            chk("t3_held_count", {16'd0, bus.conv_count}, {16'd0, held_cnt});
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3_resume_ready", {28'd0, bus.req_ready}, 32'b0100);
        cyc();

        // Sparse requesters after a grant to 2: pointer wraps through 0.
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_out_id", {30'd0, bus.out_id}, exp_ids[i]);
        end

        // Requester 1 sweeps every Gray code.
        bus.req_valid = '0;
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            bus.req_gray = 16'(((i ^ (i >> 1)) & 15) << 4);
            cyc();
            chk("t5_out_binary", {28'd0, bus.out_binary}, i);
        end
        chk("t5_conv_count", {16'd0, bus.conv_count}, 32'd16);

        // Reset while holding a word under backpressure.
        bus.req_valid = 4'b0001;
        cyc();
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_ready_in_reset", {28'd0, bus.req_ready}, 32'd0);
        cyc();
        rst = 1'b0;
        chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_conv_count", {16'd0, bus.conv_count}, 32'd0);
        bus.req_valid = 4'b1100;
        bus.out_ready = 1'b1;
        #1;
        chk("t6_first_grant", {28'd0, bus.req_ready}, 32'b0100);
        cyc();

        // Counter wrap: 65536 back-to-back conversions from zero.
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 65536; i++) begin
            bus.req_gray = 16'($urandom);
            cyc();
        end
        chk("wrap_count_zero", {16'd0, bus.conv_count}, 32'd0);
        cyc();
        chk("wrap_count_one", {16'd0, bus.conv_count}, 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.req_valid = 4'($urandom);
            bus.req_gray  = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_decode_arbiter.md
Name: gray_decode_arbiter

Overview:
- Shares one Gray-to-binary conversion datapath among NUM_REQ requesters.
- Uses a round-robin arbiter and per-requester valid/ready handshakes.
- Converted words go out through a single registered output stage, tagged with the requester ID, under valid/ready backpressure.
- Sits between Gray-coded sources (counters, encoders, CDC pointers) and binary consumers.

Parameters:
WIDTH, 4, Gray/binary word width in bits (>=2)
NUM_REQ, 4, number of requesters (>=2, power of two)
ID_W, 2, requester ID width, equal to log2(NUM_REQ)
CNT_W, 16, width of the conversion counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  request valid, one bit per requester
req_gray  input  NUM_REQ*WIDTH  Gray words; requester i occupies [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  one-hot grant/accept; may be zero
out_valid  output  1  output register holds a converted word
out_binary  output  WIDTH  converted binary word
out_id  output  ID_W  index of the requester that supplied out_binary
out_ready  input  1  consumer accepts the output this cycle
conv_count  output  CNT_W  total accepted conversions; wraps modulo 2^CNT_W
busy  output  1  high while out_valid is high (FULL state)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on the rising clk edge.
- Reset values:
  - out_valid=0, out_binary=0, out_id=0, conv_count=0, busy=0.
  - Round-robin pointer ptr=0. FSM=EMPTY.
- Conversion function (combinational, inside the block):
  - b[WIDTH-1]=g[WIDTH-1].
  - b[k]=b[k+1]^g[k] for k=WIDTH-2..0.
- can_accept = !out_valid || out_ready (same-cycle drain-and-refill allowed).
- Arbitration:
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - No grant when can_accept=0 or no req_valid is set.
- req_ready is combinational: req_ready[i]=1 only for the granted i. It depends on req_valid; requesters must not make valid depend on ready.
- A handshake on requester i is req_valid[i] && req_ready[i]. On that edge:
  - out_binary <= conv(req_gray[i]); out_id <= i; out_valid <= 1.
  - ptr <= (i+1) mod NUM_REQ; conv_count <= conv_count+1.
- When no grant occurs, ptr is unchanged.
- Latency: one cycle from accept to out_valid. Throughput is one conversion per cycle when out_ready=1 continuously.
- FSM:
  - EMPTY (out_valid=0): a grant moves to FULL; otherwise stay in EMPTY.
  - FULL (out_valid=1):
    - out_ready=1 with a grant: stay in FULL and load new data.
    - out_ready=1 with no grant: go to EMPTY, out_valid <= 0.
    - out_ready=0: stay in FULL; out_binary and out_id held stable; req_ready=0.
- Requester-side rules:
  - A requester whose valid is held is never starved: it is granted within NUM_REQ accepting cycles.
  - Requester data need only be stable in the cycle its ready is high.
  - Dropping req_valid without a handshake is permitted and has no effect.
- Reset mid-operation: any buffered word is discarded without being presented. Next cycle: out_valid=0, ptr=0, conv_count=0. req_ready=0 during the reset cycle.
- conv_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset, then req_valid=0001 with req_gray[3:0]=0110 for one cycle, out_ready=1 -> req_ready=0001 that cycle; next cycle out_valid=1, out_binary=0100, out_id=0, conv_count=1.
- All four valid continuously, out_ready=1, gray words 0001/0011/1100/1110 -> grant order 0,1,2,3,0,1; binaries 0001/0010/1000/1011 with matching out_id; one per cycle.
- Fill output, then out_ready=0 for 3 cycles with all requesters valid -> req_ready=0000, out_binary/out_id stable, conv_count unchanged. Raise out_ready -> the next grant is accepted in the same cycle, with no bubble.
- After a grant to requester 2, req_valid=1010 -> grant goes to 3, then 1 (pointer wrap), then 3.
- Requester 1 sweeps all 16 Gray codes (0000..1000 in Gray order) with out_ready=1 -> out_binary=0..15 in sequence, conv_count=16.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, conv_count=0. First post-reset grant with req_valid=1100 goes to requester 2 (ptr=0).
